// File: rtl/vga_pkg.sv
// Shared definitions for the VGA AXI4-Lite front-end: response codes,
// FSM state encodings, address-map constants and the region legality check.
package vga_pkg;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write-channel FSM states
    typedef enum logic [2:0] {
        W_IDLE,
        W_ADDR_WAIT,
        W_DATA_WAIT,
        W_COMMIT,
        W_RESP
    } wr_state_e;

    // Read-channel FSM states
    typedef enum logic [1:0] {
        R_IDLE,
        R_WAIT,
        R_RESP
    } rd_state_e;

    // Address map (byte addresses)
    localparam logic [31:0] BUF_BASE  = 32'h0000_4000;  // text buffer region
    localparam logic [31:0] BUF_LIMIT = 32'h0000_4960;  // first illegal buffer byte
    localparam logic [31:0] REG_BASE  = 32'h0000_2000;  // colour register region
    localparam logic [31:0] REG_LAST  = 32'h0000_0014;  // last legal register offset

    // True when a byte address hits an implemented location. The buffer
    // region is selected by bit 14 and the register region by bit 13; every
    // address below the register region belongs to the font memory.
    function automatic logic addr_legal(input logic [31:0] addr);
        if (addr >= BUF_BASE) begin
            return addr < BUF_LIMIT;
        end
        if (addr >= REG_BASE) begin
            return (addr - REG_BASE) <= REG_LAST;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/vga_axil_slave_if.sv
// AXI4-Lite bus bundle between an AXI master and the VGA front-end slave.
interface vga_axil_slave_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 15
);

    // Write address channel
    logic                    awvalid;
    logic                    awready;
    logic [ADDR_WIDTH-1:0]   awaddr;
    // Write data channel
    logic                    wvalid;
    logic                    wready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    // Write response channel
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    // Read address channel
    logic                    arvalid;
    logic                    arready;
    logic [ADDR_WIDTH-1:0]   araddr;
    // Read data channel
    logic                    rvalid;
    logic                    rready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
               arvalid, araddr, rready,
        output awready, wready, bvalid, bresp,
               arready, rvalid, rdata, rresp
    );

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready,
               arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp,
               arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/vga_axil_hold_cnt.sv
// Loadable down-counter with a terminal flag. Loading N-1 makes done_o rise
// on the N-th cycle after the load, which is how the hold/latency windows of
// the AXI front-end are timed.
module vga_axil_hold_cnt #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise count down and park at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WIDTH'(1);
        end
    end

    // Count register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/vga_axil_slave.sv
// AXI4-Lite slave front-end for the VGA top level (clk_i domain).
// Converts AXI-lite writes into a latched address/data/strobe bundle with a
// commit strobe held for WR_HOLD cycles, and AXI-lite reads into a read
// request held for RD_LAT cycles before the returned data is captured.
// Optional build macro: VGA_AXIL_RANGE_CHECK_EN enables address decoding;
// accesses outside the implemented regions are answered with SLVERR and
// never reach the VGA top.
module vga_axil_slave
    import vga_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH = 15,
    parameter int unsigned WR_HOLD          = 4,
    parameter int unsigned RD_LAT           = 3
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    vga_axil_slave_if.slave                 s,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
    output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
    output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
    output logic                            axil_wready_o,
    output logic                            axil_rreq_o,
    output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
    input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);

    localparam int unsigned STRB_W = C_AXI_DATA_WIDTH / 8;
    localparam int unsigned WCNT_W = (WR_HOLD > 1) ? $clog2(WR_HOLD) : 1;
    localparam int unsigned RCNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    // ------------------------------------------------------------------
    // Write path state
    // ------------------------------------------------------------------
    wr_state_e                   wr_state_q, wr_state_d;
    logic                        awready_q, awready_d;
    logic                        wready_q, wready_d;
    logic [C_AXI_ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [C_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_W-1:0]           wstrb_q, wstrb_d;
    logic [1:0]                  bresp_q, bresp_d;
    logic                        aw_fire, w_fire;
    logic                        wr_commit;
    logic                        wr_legal;
    logic                        wr_load;
    logic                        wr_done;

    // ------------------------------------------------------------------
    // Read path state
    // ------------------------------------------------------------------
    rd_state_e                   rd_state_q, rd_state_d;
    logic                        arready_q, arready_d;
    logic [C_AXI_ADDR_WIDTH-1:0] raddr_q, raddr_d;
    logic [C_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                  rresp_q, rresp_d;
    logic                        ar_fire;
    logic                        rd_legal;
    logic                        rd_load;
    logic                        rd_done;

    assign aw_fire = s.awvalid && awready_q;
    assign w_fire  = s.wvalid  && wready_q;
    assign ar_fire = s.arvalid && arready_q;

`ifdef VGA_AXIL_RANGE_CHECK_EN
    // The address that will be committed: already latched when only data
    // is outstanding, otherwise the one being accepted this cycle.
    logic [C_AXI_ADDR_WIDTH-1:0] wr_addr_next;
    assign wr_addr_next = (wr_state_q == W_DATA_WAIT) ? waddr_q : s.awaddr;
    assign wr_legal     = addr_legal(32'(wr_addr_next));
    assign rd_legal     = addr_legal(32'(s.araddr));
`else
    assign wr_legal = 1'b1;
    assign rd_legal = 1'b1;
`endif

    // Hold timers for the commit window and the read latency window
    vga_axil_hold_cnt #(.WIDTH(WCNT_W)) u_wr_hold (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (wr_load),
        .load_val_i (WCNT_W'(WR_HOLD - 1)),
        .done_o     (wr_done)
    );

    vga_axil_hold_cnt #(.WIDTH(RCNT_W)) u_rd_lat (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (rd_load),
        .load_val_i (RCNT_W'(RD_LAT - 1)),
        .done_o     (rd_done)
    );

    // Write FSM next state: collect AW and W in either order, commit, respond
    always_comb begin
        // NOTE: every signal gets its default before the case so no path
        // leaves one unassigned, which would otherwise infer a latch.
        wr_state_d = wr_state_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        wr_load    = 1'b0;

        case (wr_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    waddr_d = s.awaddr;
                end
                if (w_fire) begin
                    wdata_d = s.wdata;
                    wstrb_d = s.wstrb;
                end
                if (aw_fire && w_fire) begin
                    wr_commit = 1'b1;
                end else if (aw_fire) begin
                    wr_state_d = W_DATA_WAIT;
                end else if (w_fire) begin
                    wr_state_d = W_ADDR_WAIT;
                end
            end
            W_ADDR_WAIT: begin
                if (aw_fire) begin
                    waddr_d   = s.awaddr;
                    wr_commit = 1'b1;
                end
            end
            W_DATA_WAIT: begin
                if (w_fire) begin
                    wdata_d   = s.wdata;
                    wstrb_d   = s.wstrb;
                    wr_commit = 1'b1;
                end
            end
            W_COMMIT: begin
                if (wr_done) begin
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (s.bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: begin
                wr_state_d = W_IDLE;
            end
        endcase

        // Both halves present: legal writes go through the commit window,
        // illegal ones are answered straight away.
        if (wr_commit) begin
            if (wr_legal) begin
                wr_state_d = W_COMMIT;
                bresp_d    = RESP_OKAY;
                wr_load    = 1'b1;
            end else begin
                wr_state_d = W_RESP;
                bresp_d    = RESP_SLVERR;
            end
        end

        // Ready is registered so it is low out of reset and drops on the
        // cycle after its own handshake.
        awready_d = (wr_state_d == W_IDLE) || (wr_state_d == W_ADDR_WAIT);
        wready_d  = (wr_state_d == W_IDLE) || (wr_state_d == W_DATA_WAIT);
    end

    // Write FSM and write-side holding registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_state_q <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values regardless of statement order.
            wr_state_q <= wr_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bresp_q    <= bresp_d;
        end
    end

    // Read FSM next state: accept address, wait the latency, return data
    always_comb begin
        rd_state_d = rd_state_q;
        raddr_d    = raddr_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        rd_load    = 1'b0;

        case (rd_state_q)
            R_IDLE: begin
                if (ar_fire) begin
                    raddr_d = s.araddr;
                    if (rd_legal) begin
                        rd_state_d = R_WAIT;
                        rresp_d    = RESP_OKAY;
                        rd_load    = 1'b1;
                    end else begin
                        rd_state_d = R_RESP;
                        rdata_d    = '0;
                        rresp_d    = RESP_SLVERR;
                    end
                end
            end
            R_WAIT: begin
                // Data from the VGA top is valid only on the last wait cycle
                if (rd_done) begin
                    rdata_d    = axil_rdata_i;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (s.rready) begin
                    rd_state_d = R_IDLE;
                end
            end
            default: begin
                rd_state_d = R_IDLE;
            end
        endcase

        arready_d = (rd_state_d == R_IDLE);
    end

    // Read FSM and read-side holding registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_state_q <= R_IDLE;
            arready_q  <= 1'b0;
            raddr_q    <= '0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            arready_q  <= arready_d;
            raddr_q    <= raddr_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // AXI-side outputs
    assign s.awready = awready_q;
    assign s.wready  = wready_q;
    assign s.bvalid  = (wr_state_q == W_RESP);
    assign s.bresp   = bresp_q;
    assign s.arready = arready_q;
    assign s.rvalid  = (rd_state_q == R_RESP);
    assign s.rdata   = rdata_q;
    assign s.rresp   = rresp_q;

    // VGA-side outputs; strobes decode straight from state so reset clears
    // them without waiting for a clock edge.
    assign axil_waddr_o  = waddr_q;
    assign axil_wdata_o  = wdata_q;
    assign axil_wstrb_o  = wstrb_q;
    assign axil_wready_o = (wr_state_q == W_COMMIT);
    assign axil_rreq_o   = (rd_state_q == R_WAIT);
    assign axil_raddr_o  = raddr_q;

endmodule

// File: tb/tb_vga_axil_slave.sv
// Self-checking bench for vga_axil_slave. A transaction-level reference
// (byte-merged word memory plus latency rules) predicts every cycle of each
// AXI transaction; a simple VGA-side memory model answers read requests.
// Build with VGA_AXIL_RANGE_CHECK_EN defined to exercise address decoding.
module tb_vga_axil_slave;
    import vga_pkg::*;

    localparam int DW      = 32;
    localparam int AW      = 15;
    localparam int WR_HOLD = 4;
    localparam int RD_LAT  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    vga_axil_slave_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    logic [AW-1:0]   axil_waddr, axil_raddr;
    logic [DW-1:0]   axil_wdata, axil_rdata;
    logic [DW/8-1:0] axil_wstrb;
    logic            axil_wready, axil_rreq;

    vga_axil_slave #(
        .C_AXI_DATA_WIDTH (DW),
        .C_AXI_ADDR_WIDTH (AW),
        .WR_HOLD          (WR_HOLD),
        .RD_LAT           (RD_LAT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .s             (bus),
        .axil_waddr_o  (axil_waddr),
        .axil_wdata_o  (axil_wdata),
        .axil_wstrb_o  (axil_wstrb),
        .axil_wready_o (axil_wready),
        .axil_rreq_o   (axil_rreq),
        .axil_raddr_o  (axil_raddr),
        .axil_rdata_i  (axil_rdata)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int];
    logic [31:0] vga_mem [int];

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [AW-1:0] a);
        int k;
        k = int'(a >> 2);
        return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
    endfunction

    function automatic logic [31:0] vga_rd(input logic [AW-1:0] a);
        int k;
        k = int'(a >> 2);
        return vga_mem.exists(k) ? vga_mem[k] : 32'h0;
    endfunction

    function automatic logic ref_legal(input logic [AW-1:0] a);
`ifdef VGA_AXIL_RANGE_CHECK_EN
        if (a >= 15'h4000) return a < 15'h4960;
        if (a >= 15'h2000) return a <= 15'h2014;
        return 1'b1;
`else
        return (a == a);
`endif
    endfunction

    // VGA-side model: stores committed writes; returns read data only on the
    // last cycle of the request window and junk on every other cycle.
    int rreq_run = 0;
    always @(negedge clk) begin
        if (axil_wready)
            vga_mem[int'(axil_waddr >> 2)] = merge(vga_rd(axil_waddr), axil_wdata, axil_wstrb);
        rreq_run   = axil_rreq ? rreq_run + 1 : 0;
        axil_rdata = (rreq_run == RD_LAT) ? vga_rd(axil_raddr) : $urandom;
    end

    // ---------------- transaction tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic legal;
        int   lat, hs, limit;
        bit   aw_done, w_done, b_fire, finished, in_commit, exp_b;
        legal = ref_legal(a);
        lat   = legal ? WR_HOLD + 1 : 1;
        hs    = -1;
        limit = aw_dly + w_dly + b_dly + WR_HOLD + 8;
        aw_done = 0; w_done = 0; b_fire = 0; finished = 0;
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            @(negedge clk);
            if (b_fire) begin
                check("wr_bvalid_drop", 32'(bus.bvalid), 32'(0));
                check("wr_awready_back", 32'(bus.awready), 32'(1));
                bus.bready = 1'b0;
                finished   = 1;
            end else begin
                check("wr_awready", 32'(bus.awready), 32'(!aw_done));
                check("wr_wready", 32'(bus.wready), 32'(!w_done));
                in_commit = legal && hs >= 0 && cyc > hs && cyc <= hs + WR_HOLD;
                check("wr_commit", 32'(axil_wready), 32'(in_commit));
                if (in_commit) begin
                    check("wr_waddr", 32'(axil_waddr), 32'(a));
                    check("wr_wdata", axil_wdata, d);
                    check("wr_wstrb", 32'(axil_wstrb), 32'(s));
                end
                exp_b = hs >= 0 && cyc >= hs + lat;
                check("wr_bvalid", 32'(bus.bvalid), 32'(exp_b));
                if (exp_b)
                    check("wr_bresp", 32'(bus.bresp), 32'(legal ? RESP_OKAY : RESP_SLVERR));
                bus.awvalid = !aw_done && cyc >= aw_dly;
                bus.awaddr  = bus.awvalid ? a : '0;
                bus.wvalid  = !w_done && cyc >= w_dly;
                bus.wdata   = bus.wvalid ? d : $urandom;
                bus.wstrb   = bus.wvalid ? s : 4'h0;
                if (bus.awvalid && bus.awready) aw_done = 1;
                if (bus.wvalid && bus.wready) w_done = 1;
                if (hs < 0 && aw_done && w_done) hs = cyc;
                bus.bready = hs >= 0 && cyc >= hs + lat + b_dly;
                if (bus.bready && bus.bvalid) b_fire = 1;
            end
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b0;
        check("wr_timeout", 32'(finished), 32'(1));
        if (legal) ref_mem[int'(a >> 2)] = merge(ref_rd(a), d, s);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int ar_dly, input int r_dly);
        logic        legal;
        logic [31:0] exp_data;
        int          lat, hs, limit;
        bit          ar_done, r_fire, finished, in_req, exp_r;
        legal    = ref_legal(a);
        exp_data = legal ? ref_rd(a) : 32'h0;
        lat      = legal ? RD_LAT + 1 : 1;
        hs       = -1;
        limit    = ar_dly + r_dly + RD_LAT + 8;
        ar_done = 0; r_fire = 0; finished = 0;
        for (int cyc = 0; cyc < limit && !finished; cyc++) begin
            @(negedge clk);
            if (r_fire) begin
                check("rd_rvalid_drop", 32'(bus.rvalid), 32'(0));
                check("rd_arready_back", 32'(bus.arready), 32'(1));
                bus.rready = 1'b0;
                finished   = 1;
            end else begin
                check("rd_arready", 32'(bus.arready), 32'(!ar_done));
                in_req = legal && hs >= 0 && cyc > hs && cyc <= hs + RD_LAT;
                check("rd_rreq", 32'(axil_rreq), 32'(in_req));
                if (in_req) check("rd_raddr", 32'(axil_raddr), 32'(a));
                exp_r = hs >= 0 && cyc >= hs + lat;
                check("rd_rvalid", 32'(bus.rvalid), 32'(exp_r));
                if (exp_r) begin
                    check("rd_rdata", bus.rdata, exp_data);
                    check("rd_rresp", 32'(bus.rresp), 32'(legal ? RESP_OKAY : RESP_SLVERR));
                end
                bus.arvalid = !ar_done && cyc >= ar_dly;
                bus.araddr  = bus.arvalid ? a : '0;
                if (bus.arvalid && bus.arready) begin
                    ar_done = 1;
                    hs      = cyc;
                end
                bus.rready = hs >= 0 && cyc >= hs + lat + r_dly;
                if (bus.rready && bus.rvalid) r_fire = 1;
            end
        end
        bus.arvalid = 1'b0;
        bus.rready  = 1'b0;
        check("rd_timeout", 32'(finished), 32'(1));
    endtask

    function automatic logic [AW-1:0] pick_addr();
        logic [AW-1:0] pool [10];
        pool = '{15'h4000, 15'h4004, 15'h4010, 15'h4020, 15'h2004,
                 15'h2010, 15'h0100, 15'h1000, 15'h4A00, 15'h2018};
        if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, 32'h7FFF)) & ~AW'(3);
        return pool[$urandom_range(0, 9)];
    endfunction

    // Watchdog: never let the run hang
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] wa, ra;
        bus.awvalid = 0; bus.awaddr = '0; bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0;
        bus.bready  = 0; bus.arvalid = 0; bus.araddr = '0; bus.rready = 0;
        axil_rdata  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 32'(bus.awready), 32'(0));
        check("rst_wready", 32'(bus.wready), 32'(0));
        check("rst_arready", 32'(bus.arready), 32'(0));
        check("rst_bvalid", 32'(bus.bvalid), 32'(0));
        check("rst_rvalid", 32'(bus.rvalid), 32'(0));
        check("rst_bresp", 32'(bus.bresp), 32'(0));
        check("rst_rresp", 32'(bus.rresp), 32'(0));
        check("rst_rdata", bus.rdata, 32'(0));
        check("rst_wcommit", 32'(axil_wready), 32'(0));
        check("rst_rreq", 32'(axil_rreq), 32'(0));
        check("rst_waddr", 32'(axil_waddr), 32'(0));
        check("rst_wdata", axil_wdata, 32'(0));
        check("rst_wstrb", 32'(axil_wstrb), 32'(0));
        check("rst_raddr", 32'(axil_raddr), 32'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Directed cases
        do_write(15'h4000, 32'h41424344, 4'hF, 0, 0, 5);   // bready back-pressure
        do_write(15'h2004, 32'h0000000F, 4'hF, 2, 0, 0);   // W two cycles before AW
        do_write(15'h4010, 32'h11223344, 4'hF, 0, 0, 0);
        do_read (15'h4010, 0, 0);
        fork                                                 // concurrent AR and AW+W
            do_read (15'h4000, 0, 0);
            do_write(15'h4004, 32'hCAFEF00D, 4'hF, 0, 0, 0);
        join
        do_write(15'h4A00, 32'hDEADBEEF, 4'hF, 0, 0, 0);   // out-of-range when decoded
        do_read (15'h4A00, 0, 2);

        // Reset in the middle of a commit window with a read pending
        @(negedge clk);
        bus.awvalid = 1; bus.awaddr = 15'h0100; bus.wvalid = 1;
        bus.wdata = 32'h55AA55AA; bus.wstrb = 4'hF;
        bus.arvalid = 1; bus.araddr = 15'h4010;
        @(negedge clk);
        bus.awvalid = 0; bus.wvalid = 0; bus.arvalid = 0;
        check("mid_commit", 32'(axil_wready), 32'(1));
        check("mid_rreq", 32'(axil_rreq), 32'(1));
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_wcommit", 32'(axil_wready), 32'(0));
        check("arst_rreq", 32'(axil_rreq), 32'(0));
        check("arst_bvalid", 32'(bus.bvalid), 32'(0));
        check("arst_rvalid", 32'(bus.rvalid), 32'(0));
        check("arst_awready", 32'(bus.awready), 32'(0));
        check("arst_waddr", 32'(axil_waddr), 32'(0));
        ref_mem[int'(15'h0100 >> 2)] = 32'h55AA55AA;        // commit window was seen
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_write(15'h0100, 32'h12345678, 4'h5, 0, 1, 1);
        do_read (15'h0100, 0, 0);

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            wa = pick_addr();
            ra = pick_addr();
            case ($urandom_range(0, 2))
                0: do_write(wa, $urandom, 4'($urandom_range(0, 15)),
                            $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                1: do_read(ra, $urandom_range(0, 2), $urandom_range(0, 3));
                default: begin
                    if ((wa >> 2) == (ra >> 2)) ra = ra ^ 15'h0008;
                    fork
                        do_write(wa, $urandom, 4'hF, 0, 0, $urandom_range(0, 2));
                        do_read (ra, 0, $urandom_range(0, 2));
                    join
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
